// File: rtl/tdl_pkg.sv
// tdl_pkg: FSM states, width helpers and saturating add for the tapped delay line
package tdl_pkg;
  typedef enum logic [1:0] {IDLE, SLEW, SETTLE, DONE} state_e;
  function automatic int tap_count(int bits);
    return 2 ** bits;
  endfunction
  function automatic int ch_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int sat_add(int a, int b, int hi);
    return a + b < 0 ? 0 : (a + b > hi ? hi : a + b);
  endfunction
endpackage

// File: rtl/tdl_chain.sv
// tdl_chain: one channel of delay cells with a tap select mux (tap 0 is the undelayed input)
module delay_chain (
  input  logic in_i,
  output logic out_o
);
  assign out_o = in_i;
endmodule

module tdl_chain
  import tdl_pkg::*;
#(
  parameter int DELAY_BITS = 5
) (
  input  logic                  in_i,
  input  logic [DELAY_BITS-1:0] sel_i,
  output logic                  out_o
);
  localparam int TAPS = tap_count(DELAY_BITS);
  logic [TAPS-1:0] node;
  for (genvar g = 0; g < TAPS; g++) begin : s
    logic d;
    if (g == 0) begin : b
      assign d = in_i;
    end else begin : b
      delay_chain u_cell (.in_i(s[g-1].d), .out_o(d));
    end
    assign node[g] = d;
  end
  assign out_o = node[sel_i];
endmodule

// File: rtl/tdl_slew_ctrl.sv
// tdl_slew_ctrl: multi-channel tapped delay line with a stepped tap-update FSM; TDL_SLEW_EN enables stepped slewing, otherwise taps jump in one edge
module tdl_slew_ctrl
  import tdl_pkg::*;
#(
  parameter int DELAY_BITS = 5,
  parameter int CHANNELS   = 2,
  parameter int STEP       = 1,
  parameter int SETTLE_CYC = 4,
  parameter int RESET_TAP  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            dly_in,
  output logic [CHANNELS-1:0]            dly_out,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ch_w(CHANNELS)-1:0]      cmd_ch,
  input  logic                           cmd_rel,
  input  logic [DELAY_BITS:0]            cmd_val,
  output logic [CHANNELS*DELAY_BITS-1:0] tap_cur,
  output logic                           busy,
  output logic                           done,
  output logic                           sat
);
  localparam int TAP_MAX = tap_count(DELAY_BITS) - 1;
  localparam int CW = ch_w(CHANNELS);
`ifdef TDL_SLEW_EN
  localparam int STEP_EFF = STEP;
`else
  localparam int STEP_EFF = STEP > TAP_MAX ? STEP : TAP_MAX;
`endif
  localparam logic signed [DELAY_BITS:0] STEP_S = (DELAY_BITS+1)'(STEP_EFF);
  localparam state_e FIN = SETTLE_CYC == 0 ? DONE : SETTLE;
  state_e state_q, state_d;
  logic [DELAY_BITS-1:0] tap_q [CHANNELS];
  logic [DELAY_BITS-1:0] tap_d [CHANNELS];
  logic [CW-1:0] ch_q, ch_d;
  logic [DELAY_BITS-1:0] tgt_q, tgt_d;
  logic [7:0] cnt_q, cnt_d;
  logic sat_q, sat_d;
  logic [DELAY_BITS-1:0] acc_cur, cur, acc_tgt, nxt;
  logic signed [DELAY_BITS:0] diff, step;
  int rel_sum;
  logic rel_sat;
  assign acc_cur = tap_q[cmd_ch];
  assign cur = tap_q[ch_q];
  assign rel_sum = sat_add(int'(acc_cur), int'($signed(cmd_val)), TAP_MAX);
  assign rel_sat = rel_sum != int'(acc_cur) + int'($signed(cmd_val));
  assign acc_tgt = cmd_rel ? DELAY_BITS'(rel_sum) : cmd_val[DELAY_BITS-1:0];
  assign diff = $signed({1'b0, tgt_q}) - $signed({1'b0, cur});
  assign step = diff > STEP_S ? STEP_S : (diff < -STEP_S ? -STEP_S : diff);
  assign nxt = DELAY_BITS'($signed({1'b0, cur}) + step);
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sat = done & sat_q;
  for (genvar g = 0; g < CHANNELS; g++) begin : ch
    assign tap_cur[g*DELAY_BITS +: DELAY_BITS] = tap_q[g];
    tdl_chain #(.DELAY_BITS(DELAY_BITS)) u_chain (
      .in_i (dly_in[g]),
      .sel_i(tap_q[g]),
      .out_o(dly_out[g])
    );
  end
  // command accept, bounded tap stepping and settle countdown
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    ch_d = ch_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        ch_d = cmd_ch;
        tgt_d = acc_tgt;
        sat_d = cmd_rel & rel_sat;
        cnt_d = 8'(SETTLE_CYC);
        state_d = acc_tgt != acc_cur ? SLEW : FIN;
      end
      SLEW: begin
        tap_d[ch_q] = nxt;
        cnt_d = 8'(SETTLE_CYC);
        state_d = nxt == tgt_q ? FIN : SLEW;
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        state_d = cnt_q <= 8'd1 ? DONE : SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and tap registers; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q <= '{default: DELAY_BITS'(RESET_TAP)};
      ch_q <= '0;
      tgt_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      ch_q <= ch_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_tdl_slew_ctrl.sv
// tb_tdl_slew_ctrl: scoreboard bench for tdl_slew_ctrl (DB=5, 2 channels, STEP=3, SETTLE_CYC=4, RESET_TAP=3)
module tb_tdl_slew_ctrl;
  localparam int DB = 5, CH = 2, STEP = 3, SC = 4, RT = 3, MAXT = 31;
`ifdef TDL_SLEW_EN
  localparam int JUMP = STEP;
`else
  localparam int JUMP = STEP > MAXT ? STEP : MAXT;
`endif
  logic clk = 0, rst = 1;
  logic [CH-1:0] dly_in = '0, dly_out;
  logic cmd_valid = 0, cmd_ready, cmd_rel = 0;
  logic [0:0] cmd_ch = '0;
  logic [DB:0] cmd_val = '0;
  logic [CH*DB-1:0] tap_cur;
  logic busy, done, sat;
  typedef struct {int ch; int start; int tgt; int other; bit sat; int lat;} exp_t;
  exp_t sb[$];
  int model[CH];
  int passed = 0, total = 0;

  tdl_slew_ctrl #(.DELAY_BITS(DB), .CHANNELS(CH), .STEP(STEP), .SETTLE_CYC(SC), .RESET_TAP(RT)) dut (
    .clk(clk), .rst(rst), .dly_in(dly_in), .dly_out(dly_out), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_rel(cmd_rel), .cmd_val(cmd_val),
    .tap_cur(tap_cur), .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic int tap_of(int c);
    return int'(tap_cur[c*DB +: DB]);
  endfunction

  task automatic push_cmd(input int c, input bit rel, input logic [5:0] val);
    exp_t e;
    int raw, d;
    e.ch = c;
    e.start = model[c];
    e.other = model[1-c];
    raw = rel ? model[c] + (val[5] ? int'(val) - 64 : int'(val)) : int'(val[4:0]);
    e.tgt = raw < 0 ? 0 : (raw > MAXT ? MAXT : raw);
    e.sat = rel && raw != e.tgt;
    d = e.tgt > e.start ? e.tgt - e.start : e.start - e.tgt;
    e.lat = (d + JUMP - 1) / JUMP + SC;
    model[c] = e.tgt;
    sb.push_back(e);
    cmd_ch = 1'(c);
    cmd_rel = rel;
    cmd_val = val;
    cmd_valid = 1;
  endtask

  task automatic follow();
    exp_t e;
    int x, lat;
    e = sb[0];
    x = e.start;
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk); #1;
      x = x < e.tgt ? (e.tgt - x > JUMP ? x + JUMP : e.tgt) : (x - e.tgt > JUMP ? x - JUMP : e.tgt);
      total++;
      if (tap_of(e.ch) !== x || tap_of(1-e.ch) !== e.other || cmd_ready !== 1'b0)
        $display("FAIL slew ch%0d edge %0d: tap=%0d other=%0d ready=%b, expected tap=%0d other=%0d ready=0",
                 e.ch, k, tap_of(e.ch), tap_of(1-e.ch), cmd_ready, x, e.other);
      else passed++;
      if (done === 1'b1) begin
        lat = k;
        total++;
        if (sat !== e.sat) $display("FAIL sat ch%0d: got %b, expected %b", e.ch, sat, e.sat);
        else passed++;
      end
    end
    total++;
    if (lat !== e.lat) $display("FAIL latency ch%0d: done after %0d edges, expected %0d", e.ch, lat, e.lat);
    else passed++;
    void'(sb.pop_front());
  endtask

  task automatic run_cmd(input int c, input bit rel, input logic [5:0] val);
    push_cmd(c, rel, val);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_before_accept: got %b, expected 1", cmd_ready);
    else passed++;
    @(posedge clk); #1;
    cmd_valid = 0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL accept: busy=%b done=%b, expected busy=1 done=0", busy, done);
    else passed++;
    follow();
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL return_idle: ready=%b busy=%b done=%b, expected 1 0 0", cmd_ready, busy, done);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1;
    dly_in = 2'b01;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model = '{RT, RT};
    total++;
    if (tap_of(0) !== RT || tap_of(1) !== RT) $display("FAIL reset_taps: got %0d/%0d, expected %0d", tap_of(0), tap_of(1), RT);
    else passed++;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sat !== 1'b0)
      $display("FAIL reset_flags: ready=%b busy=%b done=%b sat=%b, expected 1 0 0 0", cmd_ready, busy, done, sat);
    else passed++;
    total++;
    if (dly_out !== 2'b01) $display("FAIL passthrough_a: got %b, expected 01", dly_out);
    else passed++;
    dly_in = 2'b10;
    #1;
    total++;
    if (dly_out !== 2'b10) $display("FAIL passthrough_b: got %b, expected 10", dly_out);
    else passed++;
  endtask

  task automatic test_absolute();
    run_cmd(0, 0, 6'd20);
    run_cmd(0, 0, 6'h25);
  endtask

  task automatic test_step();
    run_cmd(1, 0, 6'd2);
    run_cmd(1, 0, 6'd0);
    run_cmd(1, 1, 6'd7);
  endtask

  task automatic test_saturate();
    run_cmd(0, 0, 6'd2);
    run_cmd(0, 1, 6'b111011);
    run_cmd(0, 0, 6'd28);
    run_cmd(0, 1, 6'd10);
    run_cmd(0, 1, 6'b100000);
  endtask

  task automatic test_same_target();
    run_cmd(1, 0, 6'd7);
  endtask

  task automatic test_back_to_back();
    push_cmd(0, 0, 6'd10);
    @(posedge clk); #1;
    push_cmd(1, 0, 6'd20);
    follow();
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_idle: ready=%b busy=%b, expected 1 0", cmd_ready, busy);
    else passed++;
    @(posedge clk); #1;
    cmd_valid = 0;
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b, expected 1", busy);
    else passed++;
    follow();
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) $display("FAIL b2b_single: busy=%b, expected 0", busy);
      else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int dn;
    cmd_ch = 0;
    cmd_rel = 0;
    cmd_val = 6'd25;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    rst = 1;
    total++;
    if (busy !== 1'b1) $display("FAIL abort_accept: busy=%b, expected 1", busy);
    else passed++;
    @(posedge clk); #1;
    rst = 0;
    model = '{RT, RT};
    total++;
    if (tap_of(0) !== RT || tap_of(1) !== RT || busy !== 1'b0)
      $display("FAIL abort_tap: taps=%0d/%0d busy=%b, expected %0d/%0d 0", tap_of(0), tap_of(1), busy, RT, RT);
    else passed++;
    dn = 0;
    repeat (8) begin
      @(posedge clk); #1;
      dn += int'(done);
    end
    total++;
    if (dn !== 0) $display("FAIL abort_no_done: done seen %0d times, expected 0", dn);
    else passed++;
    run_cmd(0, 0, 6'd31);
  endtask

  initial begin
    test_reset();
    test_absolute();
    test_step();
    test_saturate();
    test_same_target();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
